// File: rtl/keypad_scan_pkg.sv
// keypad_scan_pkg
// Shared constants and helpers for the 4x4 keypad scanner:
//   - FSM state encoding (state_t)
//   - active-low column drive patterns, one per column index
//   - default debounce sample count
//   - row_index(): lowest-indexed low bit of a row vector
package keypad_scan_pkg;

  localparam int DEB_CNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] COL_PAT_0 = 4'b1110;
  localparam logic [3:0] COL_PAT_1 = 4'b1101;
  localparam logic [3:0] COL_PAT_2 = 4'b1011;
  localparam logic [3:0] COL_PAT_3 = 4'b0111;

  function automatic logic [3:0] col_pattern(input logic [1:0] idx);
    logic [3:0] pat;
    case (idx)
      2'd0:    pat = COL_PAT_0;
      2'd1:    pat = COL_PAT_1;
      2'd2:    pat = COL_PAT_2;
      default: pat = COL_PAT_3;
    endcase
    return pat;
  endfunction

  // Lower row wins when several rows are pulled low together.
  // Only meaningful when at least one bit is low.
  function automatic logic [1:0] row_index(input logic [3:0] row);
    logic [1:0] idx;
    if (!row[0])      idx = 2'd0;
    else if (!row[1]) idx = 2'd1;
    else if (!row[2]) idx = 2'd2;
    else              idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick.sv
// scan_tick
// Scan-rate enable generator. Counts clk cycles 0..i_scan_num-1 and raises
// o_tick for one cycle on each wrap. Produces an enable, never a clock.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   i_scan_num tick period in clk cycles (0 or 1 -> tick every cycle)
//   o_tick     one-cycle enable pulse
module scan_tick (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_scan_num,
  output logic        o_tick
);

  logic [31:0] cnt_reg;
  logic        wrap;

  // >= rather than == so that shrinking the period mid-count wraps at once
  // instead of running the counter all the way around.
  assign wrap = (i_scan_num <= 32'd1) || (cnt_reg >= (i_scan_num - 32'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      o_tick  <= 1'b0;
    end else if (wrap) begin
      cnt_reg <= '0;
      o_tick  <= 1'b1;
    end else begin
      cnt_reg <= cnt_reg + 32'd1;
      o_tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan
// 4x4 matrix keypad scanner with press and release debounce.
// One column is driven low at a time; the rows (active-low) are synchronized
// and examined on each scan tick. A press must be seen DEB_CNT consecutive
// ticks before it is accepted; the release likewise.
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   i_scan_num  scan tick period in clk cycles
//   i_row       keypad rows, active-low, asynchronous
//   o_col       keypad column drive, active-low, one-hot-low
//   o_key       last accepted key code {col, row}
//   o_key_valid one-cycle pulse per accepted press
//   o_key_held  high while accepted key is down or its release is debounced
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int DEB_CNT = DEB_CNT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_scan_num,
  input  logic [3:0]  i_row,
  output logic [3:0]  o_col,
  output logic [3:0]  o_key,
  output logic        o_key_valid,
  output logic        o_key_held
);

  localparam int CW = $clog2(DEB_CNT + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CNT);

  logic          tick;
  logic [3:0]    sync1_reg, sync2_reg;
  logic [3:0]    row_s;
  logic          row_idle;
  logic [1:0]    row_idx;
  state_t        state_reg;
  logic [1:0]    col_idx_reg;
  logic [1:0]    col_inc;
  logic [3:0]    cand_reg;
  logic [CW-1:0] match_reg, match_inc;
  logic [CW-1:0] rel_reg, rel_inc;

  scan_tick u_scan_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_scan_num (i_scan_num),
    .o_tick     (tick)
  );

  // Rows come straight from mechanical switches; two flops before any use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 4'hF;
      sync2_reg <= 4'hF;
    end else begin
      sync1_reg <= i_row;
      sync2_reg <= sync1_reg;
    end
  end

  assign row_s    = sync2_reg;
  assign row_idle = (row_s == 4'hF);
  assign row_idx  = row_index(row_s);
  assign col_inc  = col_idx_reg + 2'd1;

  // Saturating increments so the counters can never wrap back to a
  // small value and re-trigger a compare.
  assign match_inc = (match_reg < DEB_MAX) ? match_reg + CW'(1) : match_reg;
  assign rel_inc   = (rel_reg < DEB_MAX) ? rel_reg + CW'(1) : rel_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_SCAN;
      col_idx_reg <= 2'd0;
      o_col       <= COL_PAT_0;
      cand_reg    <= 4'h0;
      match_reg   <= '0;
      rel_reg     <= '0;
      o_key       <= 4'h0;
      o_key_valid <= 1'b0;
      o_key_held  <= 1'b0;
    end else begin
      o_key_valid <= 1'b0;
      if (tick) begin
        case (state_reg)
          ST_SCAN: begin
            if (row_idle) begin
              col_idx_reg <= col_inc;
              o_col       <= col_pattern(col_inc);
            end else begin
              // Column stays where it is: it identifies the key.
              cand_reg  <= {col_idx_reg, row_idx};
              match_reg <= CW'(1);
              if (DEB_CNT == 1) begin
                o_key       <= {col_idx_reg, row_idx};
                o_key_valid <= 1'b1;
                o_key_held  <= 1'b1;
                state_reg   <= ST_PRESSED;
              end else begin
                state_reg <= ST_DEBOUNCE;
              end
            end
          end

          ST_DEBOUNCE: begin
            if (!row_idle && (row_idx == cand_reg[1:0])) begin
              match_reg <= match_inc;
              if (match_inc == DEB_MAX) begin
                o_key       <= cand_reg;
                o_key_valid <= 1'b1;
                o_key_held  <= 1'b1;
                state_reg   <= ST_PRESSED;
              end
            end else begin
              // Bounce or a different row: abandon the candidate.
              state_reg   <= ST_SCAN;
              col_idx_reg <= col_inc;
              o_col       <= col_pattern(col_inc);
            end
          end

          ST_PRESSED: begin
            if (row_idle) begin
              rel_reg <= CW'(1);
              if (DEB_CNT == 1) begin
                state_reg   <= ST_SCAN;
                o_key_held  <= 1'b0;
                col_idx_reg <= col_inc;
                o_col       <= col_pattern(col_inc);
              end else begin
                state_reg <= ST_RELEASE;
              end
            end
          end

          ST_RELEASE: begin
            if (!row_idle) begin
              // Release glitch: key still down, no new press reported.
              state_reg <= ST_PRESSED;
            end else begin
              rel_reg <= rel_inc;
              if (rel_inc == DEB_MAX) begin
                state_reg   <= ST_SCAN;
                o_key_held  <= 1'b0;
                col_idx_reg <= col_inc;
                o_col       <= col_pattern(col_inc);
              end
            end
          end

          default: state_reg <= ST_SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] scan_num;
  logic [3:0]  i_row;
  logic [3:0]  o_col;
  logic [3:0]  o_key;
  logic        o_key_valid;
  logic        o_key_held;

  // Pressed-key matrix, bit index = row*4 + col.
  logic [15:0] keys;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulse_cnt = 0;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  exp_key;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (o_key_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  // Keypad model: a pressed key shorts its row to its column when driven low.
  always_comb begin
    i_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !o_col[c]) i_row[r] = 1'b0;
  end

  keypad_scan #(.DEB_CNT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_scan_num  (scan_num),
    .i_row       (i_row),
    .o_col       (o_col),
    .o_key       (o_key),
    .o_key_valid (o_key_valid),
    .o_key_held  (o_key_held)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input int base, input string name);
    for (int k = 0; k < 300 && pulse_cnt == base; k++) @(negedge clk);
    chk({name, " pulse seen"}, 32'(pulse_cnt != base), 32'd1);
  endtask

  task automatic wait_col(input logic [3:0] pat, input string name);
    for (int k = 0; k < 100 && o_col !== pat; k++) @(negedge clk);
    chk({name, " col reached"}, 32'(o_col), 32'(pat));
  endtask

  initial begin
    int base, t0, t1;
    logic [3:0] exp_col;

    vecs[0] = '{keys: 16'h0001, exp_key: 4'h0};   // r0 c0
    vecs[1] = '{keys: 16'h8000, exp_key: 4'hF};   // r3 c3
    vecs[2] = '{keys: 16'h0200, exp_key: 4'h6};   // r2 c1
    vecs[3] = '{keys: 16'h8008, exp_key: 4'hC};   // r0 c3 + r3 c3, lower row wins
    vecs[4] = '{keys: 16'h1000, exp_key: 4'h3};   // r3 c0

    keys     = 16'h0;
    scan_num = 32'd4;
    rst_n    = 1'b0;
    wait_cycles(3);
    chk("reset o_col", 32'(o_col), 32'hE);
    chk("reset o_key", 32'(o_key), 32'h0);
    chk("reset o_key_valid", 32'(o_key_valid), 32'h0);
    chk("reset o_key_held", 32'(o_key_held), 32'h0);

    // Row1 held while column 2 is driven: pulse 4 ticks after column 2 appears.
    rst_n = 1'b1;
    keys  = 16'h0040;
    wait_col(4'b1011, "seqA");
    t0 = cyc;
    for (int k = 0; k < 100 && o_key_valid !== 1'b1; k++) @(negedge clk);
    t1 = cyc;
    chk("seqA pulse latency", 32'(t1 - t0), 32'd16);
    chk("seqA o_key", 32'(o_key), 32'h9);
    @(negedge clk);
    chk("seqA pulse width", 32'(o_key_valid), 32'h0);
    chk("seqA held", 32'(o_key_held), 32'h1);
    keys = 16'h0;
    wait_cycles(40);
    chk("seqA released", 32'(o_key_held), 32'h0);

    // Table of steady presses.
    for (int v = 0; v < 5; v++) begin
      base = pulse_cnt;
      keys = vecs[v].keys;
      wait_pulse(base, $sformatf("vec%0d", v));
      wait_cycles(8);
      chk($sformatf("vec%0d o_key", v), 32'(o_key), 32'(vecs[v].exp_key));
      chk($sformatf("vec%0d held", v), 32'(o_key_held), 32'h1);
      keys = 16'h0;
      wait_cycles(40);
      chk($sformatf("vec%0d held after release", v), 32'(o_key_held), 32'h0);
      chk($sformatf("vec%0d one pulse", v), 32'(pulse_cnt - base), 32'd1);
      chk($sformatf("vec%0d o_key kept", v), 32'(o_key), 32'(vecs[v].exp_key));
    end

    // Bounce on row0/col0: no acceptance, column released to 1101.
    base = pulse_cnt;
    for (int k = 0; k < 100 && o_col === 4'b1110; k++) @(negedge clk);
    wait_col(4'b1110, "bounce");
    keys = 16'h0001;
    wait_cycles(4);
    chk("bounce col frozen", 32'(o_col), 32'hE);
    keys = 16'h0;
    wait_cycles(4);
    chk("bounce col resumes", 32'(o_col), 32'hD);
    keys = 16'h0001;
    wait_cycles(4);
    keys = 16'h0;
    wait_cycles(20);
    chk("bounce no pulse", 32'(pulse_cnt - base), 32'd0);
    chk("bounce o_key unchanged", 32'(o_key), 32'h3);
    chk("bounce held", 32'(o_key_held), 32'h0);

    // Key 5 held 100 ticks, glitch on release, then real release.
    base = pulse_cnt;
    keys = 16'h0020;
    wait_pulse(base, "hold");
    wait_cycles(400);
    chk("hold one pulse", 32'(pulse_cnt - base), 32'd1);
    chk("hold o_key", 32'(o_key), 32'h5);
    chk("hold held", 32'(o_key_held), 32'h1);
    keys = 16'h0;
    wait_cycles(8);
    keys = 16'h0020;
    wait_cycles(20);
    chk("glitch held", 32'(o_key_held), 32'h1);
    keys = 16'h0;
    wait_cycles(8);
    chk("release held early", 32'(o_key_held), 32'h1);
    wait_cycles(16);
    chk("release held late", 32'(o_key_held), 32'h0);
    chk("hold total pulses", 32'(pulse_cnt - base), 32'd1);

    // Asynchronous reset while PRESSED.
    base = pulse_cnt;
    keys = 16'h0200;
    wait_pulse(base, "rst");
    wait_cycles(5);
    base  = pulse_cnt;
    rst_n = 1'b0;
    keys  = 16'h0;
    #1;
    chk("rst o_col", 32'(o_col), 32'hE);
    chk("rst o_key", 32'(o_key), 32'h0);
    chk("rst o_key_valid", 32'(o_key_valid), 32'h0);
    chk("rst o_key_held", 32'(o_key_held), 32'h0);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(20);
    chk("rst no pulse", 32'(pulse_cnt - base), 32'd0);
    chk("rst o_key after", 32'(o_key), 32'h0);

    // i_scan_num = 0: column rotates every cycle.
    scan_num = 32'd0;
    wait_cycles(4);
    exp_col = o_col;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_col = {exp_col[2:0], exp_col[3]};
      chk($sformatf("rotate step%0d", i), 32'(o_col), 32'(exp_col));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
